// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a small queue toward decode, local jump resolution and execute redirects.
module fetch_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH = 2,
  parameter logic [3:0] JMP_OPCODE = 4'hC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] instr_address,
  output logic              stall,
  output logic              branch,
  output logic [ADDR_W-1:0] br_address,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic accept, is_jmp, flush, push, pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign mem_addr = instr_address;
  assign mem_req = state == FETCH && count < CW'(DEPTH);
  assign accept = mem_req && mem_ack;
  assign stall = state == IDLE || (state == FETCH && !accept);
  assign branch = state == REDIR;
  assign br_address = target;
  assign is_jmp = mem_rdata[15:12] == JMP_OPCODE;
  // A redirect wins over everything: acked words and pops in that cycle are dropped
  assign flush = ex_redirect && state != IDLE;
  assign push = accept && !is_jmp && !flush;
  assign pop = instr_valid && instr_ready && !flush;
  assign instr_valid = count != '0;
  assign instr_out = q_data[rd_ptr];
  assign instr_pc = q_pc[rd_ptr];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      target <= '0;
    end else begin
      state <= state == IDLE ? FETCH : (flush || (accept && is_jmp)) ? REDIR : FETCH;
      target <= flush ? ex_target : (accept && is_jmp) ? mem_rdata[ADDR_W-1:0] : target;
      count <= flush ? '0 : count + CW'(push) - CW'(pop);
      rd_ptr <= flush ? '0 : pop ? inc(rd_ptr) : rd_ptr;
      wr_ptr <= flush ? '0 : push ? inc(wr_ptr) : wr_ptr;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr] <= instr_address;
      q_data[wr_ptr] <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand-written corner sequences and a randomized run against a program-walk model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] pc;
  logic stall, branch, mem_req, mem_ack, ex_redirect, instr_valid, instr_ready;
  logic [9:0] br_address, mem_addr, ex_target, instr_pc;
  logic [15:0] mem_rdata, instr_out;
  logic [15:0] imem [1024];
  logic spur;
  int lat, wcnt;
  int n_chk = 0;
  int n_fail = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .instr_address(pc), .stall(stall), .branch(branch),
    .br_address(br_address), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // PC model: branch has priority over stall
  always @(posedge clk or posedge reset)
    if (reset) pc <= '0;
    else if (branch) pc <= br_address;
    else if (!stall) pc <= pc + 10'd1;

  // Memory model: acks after lat waiting cycles; spur forces an extra ack
  always @(posedge clk or posedge reset)
    if (reset) wcnt <= 0;
    else if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  assign mem_ack = (mem_req && wcnt >= lat) || spur;
  assign mem_rdata = imem[mem_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    instr_ready = 1'b0;
    ex_redirect = 1'b0;
    ex_target = '0;
    spur = 1'b0;
    lat = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst mem_req", 32'(mem_req), 0);
    check("rst stall", 32'(stall), 1);
    check("rst branch", 32'(branch), 0);
    check("rst br_address", 32'(br_address), 0);
    check("rst instr_valid", 32'(instr_valid), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    int start, rdy, rd, tg, sp;
    int req, addr, stl, br, bra, vld, ipc, iout;
  } vec_t;
  vec_t tv [21];

  logic [9:0] mpc;
  task automatic next_exp(output logic [9:0] a, output logic [15:0] w);
    for (int k = 0; k < 4 && imem[mpc][15:12] == 4'hC; k++) mpc = imem[mpc][9:0];
    a = mpc;
    w = imem[mpc];
    mpc = mpc + 10'd1;
  endtask

  initial begin
    logic [9:0] ea;
    logic [15:0] ew;
    logic [3:0] nib;
    logic pend, pre_rd;
    logic [9:0] paddr;
    int npop;
    // start rdy rd tg sp | req addr stl br bra vld ipc iout
    tv[0]  = '{1,1,0,0,0, 0,0,1,0,0, 0,0,0};
    tv[1]  = '{0,1,0,0,0, 1,0,0,0,0, 0,0,0};
    tv[2]  = '{0,1,0,0,0, 1,1,0,0,0, 1,0,'h1111};
    tv[3]  = '{0,1,0,0,0, 1,2,0,0,0, 1,1,'h2222};
    tv[4]  = '{0,1,0,0,0, 1,3,0,0,0, 1,2,'h3333};
    tv[5]  = '{1,0,0,0,0, 0,0,1,0,0, 0,0,0};
    tv[6]  = '{0,0,0,0,0, 1,0,0,0,0, 0,0,0};
    tv[7]  = '{0,0,0,0,0, 1,1,0,0,0, 1,0,'h1111};
    tv[8]  = '{0,0,0,0,0, 0,2,1,0,0, 1,0,'h1111};
    tv[9]  = '{0,0,0,0,0, 0,2,1,0,0, 1,0,'h1111};
    tv[10] = '{0,1,0,0,0, 0,2,1,0,0, 1,0,'h1111};
    tv[11] = '{0,1,0,0,0, 1,2,0,0,0, 1,1,'h2222};
    tv[12] = '{0,1,0,0,0, 1,3,0,0,0, 1,2,'h3333};
    tv[13] = '{1,0,0,0,0, 0,0,1,0,0, 0,0,0};
    tv[14] = '{0,0,0,0,0, 1,0,0,0,0, 0,0,0};
    tv[15] = '{0,0,0,0,0, 1,1,0,0,0, 1,0,'h1111};
    tv[16] = '{0,0,0,0,0, 0,2,1,0,0, 1,0,'h1111};
    tv[17] = '{0,1,1,2,1, 0,2,1,0,0, 1,0,'h1111};
    tv[18] = '{0,1,0,0,0, 0,2,0,1,2, 0,0,0};
    tv[19] = '{0,1,0,0,0, 1,2,0,0,0, 0,0,0};
    tv[20] = '{0,1,0,0,0, 1,3,0,0,0, 1,2,'h3333};
    for (int a = 0; a < 1024; a++) imem[a] = {6'h04, 10'(a)};
    for (int a = 0; a < 8; a++) imem[a] = 16'(16'h1111 * (a + 1));

    for (int i = 0; i < 21; i++) begin
      if (tv[i].start != 0) do_reset();
      else @(negedge clk);
      instr_ready = tv[i].rdy[0];
      ex_redirect = tv[i].rd[0];
      ex_target = 10'(tv[i].tg);
      spur = tv[i].sp[0];
      #1;
      check($sformatf("row%0d mem_req", i), 32'(mem_req), tv[i].req);
      check($sformatf("row%0d mem_addr", i), 32'(mem_addr), tv[i].addr);
      check($sformatf("row%0d stall", i), 32'(stall), tv[i].stl);
      check($sformatf("row%0d branch", i), 32'(branch), tv[i].br);
      check($sformatf("row%0d instr_valid", i), 32'(instr_valid), tv[i].vld);
      if (tv[i].br != 0) check($sformatf("row%0d br_address", i), 32'(br_address), tv[i].bra);
      if (tv[i].vld != 0) begin
        check($sformatf("row%0d instr_pc", i), 32'(instr_pc), tv[i].ipc);
        check($sformatf("row%0d instr_out", i), 32'(instr_out), tv[i].iout);
      end
    end

    // Jump word at address 1 targeting 3
    imem[1] = 16'hC003;
    do_reset();
    instr_ready = 1'b1;
    @(negedge clk); #1;
    check("jmp req0", 32'(mem_req), 1);
    @(negedge clk); #1;
    check("jmp addr1", 32'(mem_addr), 1);
    check("jmp head", 32'(instr_out), 'h1111);
    @(negedge clk); #1;
    check("jmp branch", 32'(branch), 1);
    check("jmp br_address", 32'(br_address), 3);
    check("jmp req_off", 32'(mem_req), 0);
    check("jmp not_queued", 32'(instr_valid), 0);
    @(negedge clk); #1;
    check("jmp branch_once", 32'(branch), 0);
    check("jmp addr3", 32'(mem_addr), 3);
    @(negedge clk); #1;
    check("jmp tgt_pc", 32'(instr_pc), 3);
    check("jmp tgt_out", 32'(instr_out), 'h4444);

    // Reset asserted while in REDIR
    do_reset();
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst branch", 32'(branch), 1);
    reset = 1'b1;
    #1;
    check("async branch", 32'(branch), 0);
    check("async valid", 32'(instr_valid), 0);
    check("async mem_req", 32'(mem_req), 0);
    check("async stall", 32'(stall), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("restart req", 32'(mem_req), 1);
    check("restart addr", 32'(mem_addr), 0);
    @(negedge clk); #1;
    check("restart out", 32'(instr_out), 'h1111);

    // Slow memory: 3 waiting cycles before ack
    imem[1] = 16'h2222;
    do_reset();
    instr_ready = 1'b1;
    lat = 3;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("wait%0d stall", i), 32'(stall), 1);
      check($sformatf("wait%0d addr", i), 32'(mem_addr), 0);
      check($sformatf("wait%0d req", i), 32'(mem_req), 1);
    end
    @(negedge clk); #1;
    check("ack stall", 32'(stall), 0);
    check("ack addr", 32'(mem_addr), 0);
    @(negedge clk); #1;
    check("slow head", 32'(instr_out), 'h1111);
    check("slow restall", 32'(stall), 1);

    // Randomized run; even addresses never hold jumps so the walk always progresses
    for (int a = 0; a < 1024; a++) begin
      nib = 4'($urandom_range(0, 14));
      if (nib >= 4'hC) nib = nib + 4'd1;
      imem[a] = {nib, 12'($urandom)};
      if (a % 2 == 1 && $urandom_range(0, 3) == 0) imem[a] = {6'h30, 9'($urandom), 1'b0};
    end
    do_reset();
    mpc = '0;
    pend = 1'b0;
    pre_rd = 1'b0;
    paddr = '0;
    npop = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0) @(negedge clk);
      instr_ready = $urandom_range(0, 3) != 0;
      lat = $urandom_range(0, 2);
      spur = $urandom_range(0, 9) == 0;
      ex_redirect = c > 3 && $urandom_range(0, 24) == 0;
      ex_target = 10'($urandom);
      #1;
      if (pend && !pre_rd) begin
        check("hold req", 32'(mem_req), 1);
        check("hold addr", 32'(mem_addr), 32'(paddr));
      end
      if (branch) check("branch no req", 32'(mem_req), 0);
      if (instr_valid && instr_ready && !ex_redirect) begin
        next_exp(ea, ew);
        check($sformatf("rand%0d pc", c), 32'(instr_pc), 32'(ea));
        check($sformatf("rand%0d out", c), 32'(instr_out), 32'(ew));
        npop++;
      end
      if (ex_redirect) mpc = ex_target;
      pend = mem_req && !mem_ack;
      paddr = mem_addr;
      pre_rd = ex_redirect;
    end
    check("rand progress", 32'(npop > 200), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
